// File: rtl/axis_video_pkg.sv
// Shared types and constants for the AXI4-Stream video frame generator:
// FSM state encoding, pattern_sel codes and the noise LFSR definition.
package axis_video_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StHblank
  } state_e;

  localparam logic [1:0] PatHRamp   = 2'd0;
  localparam logic [1:0] PatVRamp   = 2'd1;
  localparam logic [1:0] PatChecker = 2'd2;
  localparam logic [1:0] PatDiag    = 2'd3;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {s[14:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/axis_pattern_calc.sv
// Combinational test-pattern pixel generator: maps (x, y, pattern_sel) to a pixel value.
module axis_pattern_calc
  import axis_video_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM_WIDTH  = 12
) (
  input  logic [DIM_WIDTH-1:0]  x,
  input  logic [DIM_WIDTH-1:0]  y,
  input  logic [1:0]            pattern_sel,
  output logic [DATA_WIDTH-1:0] pixel
);

  logic [DIM_WIDTH:0] sum;

  always_comb begin
    sum   = {1'b0, x} + {1'b0, y};
    pixel = '0;
    unique case (pattern_sel)
      PatHRamp:   pixel = DATA_WIDTH'(x);
      PatVRamp:   pixel = DATA_WIDTH'(y);
      PatChecker: pixel = (x[3] ^ y[3]) ? '1 : '0;
      default:    pixel = DATA_WIDTH'(sum);
    endcase
  end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI4-Stream video test-frame master with per-line blanking and selectable patterns.
// Define AXIS_FRAME_GEN_NOISE_EN to XOR LFSR noise onto tdata[1:0].
module axis_frame_gen
  import axis_video_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM_WIDTH  = 12
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_aresetn,
  input  logic                  enable,
  input  logic [DIM_WIDTH-1:0]  frame_width,
  input  logic [DIM_WIDTH-1:0]  frame_height,
  input  logic [7:0]            hblank_len,
  input  logic [1:0]            pattern_sel,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  frame_done
);

  localparam logic [DIM_WIDTH-1:0] DimOne = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0] DimTwo = DIM_WIDTH'(2);

  state_e                state_q, state_d;
  logic [DIM_WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic [DIM_WIDTH-1:0]  w_q, w_d, h_q, h_d;
  logic [7:0]            hbl_q, hbl_d, blank_q, blank_d;
  logic [1:0]            pat_q, pat_d;
  logic                  tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [DATA_WIDTH-1:0] pix, pix_out;
  logic                  accept, load_beat;

  assign accept = tvalid_q & m_axis_tready;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    hbl_d     = hbl_q;
    pat_d     = pat_q;
    blank_d   = blank_q;
    tvalid_d  = tvalid_q;
    tuser_d   = tuser_q;
    tlast_d   = tlast_q;
    done_d    = 1'b0;
    load_beat = 1'b0;

    unique case (state_q)
      StIdle: begin
        tvalid_d = 1'b0;
        tuser_d  = 1'b0;
        tlast_d  = 1'b0;
        if (enable && (frame_width >= DimTwo) && (frame_height != '0)) begin
          w_d       = frame_width;
          h_d       = frame_height;
          hbl_d     = hblank_len;
          pat_d     = pattern_sel;
          x_d       = '0;
          y_d       = '0;
          state_d   = StActive;
          load_beat = 1'b1;
        end
      end
      StActive: begin
        if (accept) begin
          if (tlast_q) begin
            x_d = '0;
            if (y_q == h_q - DimOne) begin
              // Final line: no blanking, straight back to idle.
              y_d      = '0;
              state_d  = StIdle;
              tvalid_d = 1'b0;
              tuser_d  = 1'b0;
              tlast_d  = 1'b0;
              done_d   = 1'b1;
            end else begin
              y_d = y_q + DimOne;
              if (hbl_q == 8'd0) begin
                load_beat = 1'b1;
              end else begin
                state_d  = StHblank;
                blank_d  = hbl_q;
                tvalid_d = 1'b0;
                tuser_d  = 1'b0;
                tlast_d  = 1'b0;
              end
            end
          end else begin
            x_d       = x_q + DimOne;
            load_beat = 1'b1;
          end
        end
      end
      StHblank: begin
        if (blank_q == 8'd1) begin
          blank_d   = 8'd0;
          state_d   = StActive;
          load_beat = 1'b1;
        end else begin
          blank_d = blank_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_beat) begin
      tvalid_d = 1'b1;
      tuser_d  = (x_d == '0) && (y_d == '0);
      tlast_d  = (x_d == w_d - DimOne);
    end
  end

  axis_pattern_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_pattern_calc (
    .x           (x_d),
    .y           (y_d),
    .pattern_sel (pat_d),
    .pixel       (pix)
  );

`ifdef AXIS_FRAME_GEN_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // lfsr_d is the noise state that belongs to the beat being loaded this cycle.
  always_comb begin
    lfsr_d = lfsr_q;
    if ((state_q == StIdle) && load_beat) begin
      lfsr_d = LfsrSeed;
    end else if (accept) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign pix_out = pix ^ DATA_WIDTH'(lfsr_d[1:0]);
`else
  assign pix_out = pix;
`endif

  always_comb begin
    tdata_d = tdata_q;
    if (load_beat) begin
      tdata_d = pix_out;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      hbl_q    <= '0;
      pat_q    <= '0;
      blank_q  <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      hbl_q    <= hbl_d;
      pat_q    <= pat_d;
      blank_q  <= blank_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
      tdata_q  <= tdata_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_done    = done_q;

endmodule
